// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates on issue, captures CDB results,
// retires the head through the regfile commit port and flushes on a branch mispredict.
module reorder_buffer #(
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd,
    output logic [ROB_WIDTH-1:0] issue_rob_id,
    output logic                 rob_full,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob_id,
    input  logic [31:0]          cdb_val,
    input  logic                 cdb_mispredict,
    input  logic [31:0]          cdb_target,
    input  logic [ROB_WIDTH-1:0] search_rob_id_1,
    output logic                 search_ready_1,
    output logic [31:0]          search_val_1,
    input  logic [ROB_WIDTH-1:0] search_rob_id_2,
    output logic                 search_ready_2,
    output logic [31:0]          search_val_2,
    output logic                 commit_ready,
    output logic [4:0]           commit_reg_id,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic                 store_commit,
    output logic                 clear,
    output logic [31:0]          clear_pc
);
    localparam int ROB_SIZE = 1 << ROB_WIDTH;

    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] mispredict;
    logic [1:0]          entry_type   [ROB_SIZE];
    logic [4:0]          entry_rd     [ROB_SIZE];
    logic [31:0]         entry_val    [ROB_SIZE];
    logic [31:0]         entry_target [ROB_SIZE];

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic                 flush_pending;
    logic [31:0]          pend_pc;

    logic issue_fire;
    logic commit_fire;
    logic cdb_fire;

    assign issue_rob_id = tail;
    assign rob_full     = (count == (ROB_WIDTH+1)'(ROB_SIZE));

    assign issue_fire  = issue_valid & ~rob_full & ~flush_pending & ~clear;
    assign commit_fire = busy[head] & ready[head] & ~flush_pending & ~clear;
    assign cdb_fire    = cdb_valid & busy[cdb_rob_id] & ~clear;

    // A result broadcast in the same cycle is forwarded so the regfile sees it immediately.
    always_comb begin
        search_ready_1 = ready[search_rob_id_1];
        search_val_1   = entry_val[search_rob_id_1];
        if (cdb_valid && (cdb_rob_id == search_rob_id_1)) begin
            search_ready_1 = 1'b1;
            search_val_1   = cdb_val;
        end
        search_ready_2 = ready[search_rob_id_2];
        search_val_2   = entry_val[search_rob_id_2];
        if (cdb_valid && (cdb_rob_id == search_rob_id_2)) begin
            search_ready_2 = 1'b1;
            search_val_2   = cdb_val;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            ready         <= '0;
            mispredict    <= '0;
            flush_pending <= 1'b0;
            pend_pc       <= '0;
            commit_ready  <= 1'b0;
            commit_reg_id <= '0;
            commit_val    <= '0;
            commit_rob_id <= '0;
            store_commit  <= 1'b0;
            clear         <= 1'b0;
            clear_pc      <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entry_type[i]   <= '0;
                entry_rd[i]     <= '0;
                entry_val[i]    <= '0;
                entry_target[i] <= '0;
            end
        end else if (rdy_in) begin
            commit_ready <= 1'b0;
            store_commit <= 1'b0;
            if (flush_pending) begin
                // The mispredicting branch has already retired; discard everything younger.
                clear         <= 1'b1;
                clear_pc      <= pend_pc;
                flush_pending <= 1'b0;
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                busy          <= '0;
                ready         <= '0;
            end else begin
                clear <= 1'b0;

                if (cdb_fire) begin
                    ready[cdb_rob_id]        <= 1'b1;
                    entry_val[cdb_rob_id]    <= cdb_val;
                    mispredict[cdb_rob_id]   <= cdb_mispredict;
                    entry_target[cdb_rob_id] <= cdb_target;
                end

                if (commit_fire) begin
                    commit_ready  <= 1'b1;
                    commit_reg_id <= (entry_type[head] == TYPE_STORE) ? 5'd0 : entry_rd[head];
                    commit_val    <= entry_val[head];
                    commit_rob_id <= head;
                    store_commit  <= (entry_type[head] == TYPE_STORE);
                    busy[head]    <= 1'b0;
                    head          <= head + ROB_WIDTH'(1);
                    if ((entry_type[head] == TYPE_BRANCH) && mispredict[head]) begin
                        flush_pending <= 1'b1;
                        pend_pc       <= entry_target[head];
                    end
                end

                if (issue_fire) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    entry_type[tail] <= issue_type;
                    entry_rd[tail]   <= issue_rd;
                    tail             <= tail + ROB_WIDTH'(1);
                end

                case ({issue_fire, commit_fire})
                    2'b10:   count <= count + (ROB_WIDTH+1)'(1);
                    2'b01:   count <= count - (ROB_WIDTH+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against an in-order queue model.
module tb_reorder_buffer;
    localparam int W = 3;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_in, rdy_in;
    logic         issue_valid;
    logic [1:0]   issue_type;
    logic [4:0]   issue_rd;
    logic [W-1:0] issue_rob_id;
    logic         rob_full;
    logic         cdb_valid;
    logic [W-1:0] cdb_rob_id;
    logic [31:0]  cdb_val;
    logic         cdb_mispredict;
    logic [31:0]  cdb_target;
    logic [W-1:0] search_rob_id_1, search_rob_id_2;
    logic         search_ready_1, search_ready_2;
    logic [31:0]  search_val_1, search_val_2;
    logic         commit_ready;
    logic [4:0]   commit_reg_id;
    logic [31:0]  commit_val;
    logic [W-1:0] commit_rob_id;
    logic         store_commit;
    logic         clear;
    logic [31:0]  clear_pc;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_rob_id(issue_rob_id), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .search_rob_id_1(search_rob_id_1), .search_ready_1(search_ready_1), .search_val_1(search_val_1),
        .search_rob_id_2(search_rob_id_2), .search_ready_2(search_ready_2), .search_val_2(search_val_2),
        .commit_ready(commit_ready), .commit_reg_id(commit_reg_id), .commit_val(commit_val),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit),
        .clear(clear), .clear_pc(clear_pc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: program-order queue of live entry ids plus per-id records.
    int          q[$];
    int          nxt;
    bit          live [N];
    bit          rdy_m [N];
    int          typ [N];
    logic [4:0]  rd_m [N];
    logic [31:0] val_m [N];
    bit          mis_m [N];
    logic [31:0] tgt_m [N];
    bit          fp;
    logic [31:0] pend;
    bit          known = 0;
    bit          reset_edge;
    bit          e_cr, e_st, e_clr;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_cpc;
    int          e_id;

    task automatic model_edge();
        bit iss, com, was_clr, was_fp;
        int h;
        reset_edge = 0;
        if (!rst_in) begin
            q.delete(); nxt = 0; fp = 0; pend = 0;
            for (int i = 0; i < N; i++) begin
                live[i] = 0; rdy_m[i] = 0; val_m[i] = 0; mis_m[i] = 0;
            end
            e_cr = 0; e_st = 0; e_clr = 0; e_rd = 0; e_val = 0; e_cpc = 0; e_id = 0;
            known = 1; reset_edge = 1;
            return;
        end
        if (!rdy_in) return;
        was_clr = e_clr; was_fp = fp;
        e_cr = 0; e_st = 0;
        if (was_fp) begin
            e_clr = 1; e_cpc = pend; fp = 0; q.delete(); nxt = 0;
            for (int i = 0; i < N; i++) begin live[i] = 0; rdy_m[i] = 0; end
            return;
        end
        e_clr = 0;
        iss = issue_valid && (q.size() < N) && !was_clr;
        com = (q.size() > 0) && rdy_m[q[0]] && !was_clr;
        h = (q.size() > 0) ? q[0] : 0;
        if (com) begin
            e_cr = 1;
            e_st = (typ[h] == 2);
            e_rd = (typ[h] == 2) ? 5'd0 : rd_m[h];
            e_val = val_m[h];
            e_id = h;
            if (typ[h] == 1 && mis_m[h]) begin fp = 1; pend = tgt_m[h]; end
        end
        if (cdb_valid && live[cdb_rob_id] && !was_clr) begin
            rdy_m[cdb_rob_id] = 1; val_m[cdb_rob_id] = cdb_val;
            mis_m[cdb_rob_id] = cdb_mispredict; tgt_m[cdb_rob_id] = cdb_target;
        end
        if (com) begin
            void'(q.pop_front());
            live[h] = 0;
        end
        if (iss) begin
            live[nxt] = 1; rdy_m[nxt] = 0; typ[nxt] = int'(issue_type); rd_m[nxt] = issue_rd;
            q.push_back(nxt);
            nxt = (nxt + 1) % N;
        end
    endtask

    task automatic check_search(input string tag, input int id, input logic r, input logic [31:0] v);
        bit byp;
        byp = cdb_valid && (int'(cdb_rob_id) == id);
        check({tag, "_ready"}, 32'(r), 32'(rdy_m[id] || byp));
        if (rdy_m[id] || byp) check({tag, "_val"}, v, byp ? cdb_val : val_m[id]);
    endtask

    task automatic cycle();
        #1;
        if (known) begin
            check("issue_rob_id", 32'(issue_rob_id), 32'(nxt));
            check("rob_full", 32'(rob_full), 32'(q.size() == N));
            check_search("search1", int'(search_rob_id_1), search_ready_1, search_val_1);
            check_search("search2", int'(search_rob_id_2), search_ready_2, search_val_2);
        end
        model_edge();
        @(posedge clk);
        #1;
        if (known) begin
            check("commit_ready", 32'(commit_ready), 32'(e_cr));
            check("store_commit", 32'(store_commit), 32'(e_st));
            check("clear", 32'(clear), 32'(e_clr));
            if (e_cr || reset_edge) begin
                check("commit_reg_id", 32'(commit_reg_id), 32'(e_rd));
                check("commit_val", commit_val, e_val);
                check("commit_rob_id", 32'(commit_rob_id), 32'(e_id));
            end
            if (e_clr || reset_edge) check("clear_pc", clear_pc, e_cpc);
        end
    endtask

    task automatic idle();
        issue_valid = 0; cdb_valid = 0; cdb_mispredict = 0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd);
        idle(); issue_valid = 1; issue_type = t; issue_rd = rd;
    endtask

    task automatic cdb(input int id, input logic [31:0] v, input logic m, input logic [31:0] tg);
        idle(); cdb_valid = 1; cdb_rob_id = W'(id); cdb_val = v; cdb_mispredict = m; cdb_target = tg;
    endtask

    task automatic do_reset();
        idle(); rdy_in = 1; rst_in = 0;
        cycle(); cycle();
        rst_in = 1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (q.size() > 0 || fp || e_clr); k++) begin
            idle();
            if (q.size() > 0 && !rdy_m[q[0]]) cdb(q[0], $urandom, 1'b0, 32'h0);
            cycle();
        end
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_in = 0; rdy_in = 1; idle();
        issue_type = 0; issue_rd = 0; cdb_rob_id = 0; cdb_val = 0; cdb_target = 0;
        search_rob_id_1 = 0; search_rob_id_2 = 0;

        // 1: basic issue / writeback / retire
        do_reset();
        check("t1_reset_clear", 32'(clear), 32'd0);
        issue(2'd0, 5'd5);
        #1 check("t1_issue_id", 32'(issue_rob_id), 32'd0);
        cycle();
        cdb(0, 32'h1234, 1'b0, 32'h0); cycle();
        idle(); cycle();
        check("t1_commit", 32'(commit_ready), 32'd1);
        check("t1_rd", 32'(commit_reg_id), 32'd5);
        check("t1_val", commit_val, 32'h1234);
        idle(); cycle();
        check("t1_pulse", 32'(commit_ready), 32'd0);

        // 2: full, blocked issue, commit does not unblock same cycle, wrap
        do_reset();
        for (int i = 0; i < N; i++) begin issue(2'(i % 3), 5'(i + 1)); cycle(); end
        check("t2_full", 32'(rob_full), 32'd1);
        issue(2'd0, 5'd9); cycle();
        check("t2_tail_hold", 32'(issue_rob_id), 32'd0);
        cdb(0, 32'hA0, 1'b0, 32'h0); issue_valid = 1; cycle();
        issue(2'd0, 5'd9); cycle();
        check("t2_commit0", 32'(commit_ready), 32'd1);
        check("t2_blocked", 32'(issue_rob_id), 32'd0);
        issue(2'd0, 5'd9); cycle();
        check("t2_wrap", 32'(issue_rob_id), 32'd1);
        drain();

        // 3: out-of-order writeback, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin issue(2'd0, 5'(i + 10)); cycle(); end
        for (int i = 2; i >= 0; i--) begin cdb(i, 32'(100 + i), 1'b0, 32'h0); cycle(); end
        for (int i = 0; i < 3; i++) begin
            idle(); cycle();
            check("t3_order", 32'(commit_rob_id), 32'(i));
            check("t3_ready", 32'(commit_ready), 32'd1);
        end

        // 4: search with CDB bypass
        do_reset();
        for (int i = 0; i < 4; i++) begin issue(2'd0, 5'(i + 1)); cycle(); end
        idle(); search_rob_id_1 = 3;
        #1 check("t4_not_ready", 32'(search_ready_1), 32'd0);
        cycle();
        cdb(3, 32'hBEEF, 1'b0, 32'h0);
        #1 check("t4_bypass_ready", 32'(search_ready_1), 32'd1);
        check("t4_bypass_val", search_val_1, 32'hBEEF);
        cycle();
        drain();

        // 5: mispredicted branch flush
        do_reset();
        issue(2'd1, 5'd1); cycle();
        issue(2'd0, 5'd2); cycle();
        cdb(1, 32'h55, 1'b0, 32'h0); cycle();
        cdb(0, 32'h44, 1'b1, 32'h100); cycle();
        idle(); cycle();
        check("t5_commit_br", 32'(commit_rob_id), 32'd0);
        check("t5_link", commit_val, 32'h44);
        idle(); cycle();
        check("t5_clear", 32'(clear), 32'd1);
        check("t5_clear_pc", clear_pc, 32'h100);
        check("t5_no_commit", 32'(commit_ready), 32'd0);
        idle(); cycle();
        check("t5_clear_drop", 32'(clear), 32'd0);
        check("t5_id1_dropped", 32'(commit_ready), 32'd0);
        check("t5_empty", 32'(issue_rob_id), 32'd0);

        // 6: rdy_in freeze, then reset during pending flush
        do_reset();
        issue(2'd0, 5'd7); cycle();
        cdb(0, 32'h9, 1'b0, 32'h0); cycle();
        idle(); rdy_in = 0;
        for (int i = 0; i < 3; i++) begin cycle(); check("t6_frozen", 32'(commit_ready), 32'd0); end
        rdy_in = 1; cycle();
        check("t6_commit", 32'(commit_ready), 32'd1);
        issue(2'd1, 5'd3); cycle();
        cdb(1, 32'h8, 1'b1, 32'h200); cycle();
        idle(); cycle();
        check("t6_br_commit", 32'(commit_ready), 32'd1);
        rst_in = 0; cycle();
        rst_in = 1;
        check("t6_rst_clear", 32'(clear), 32'd0);
        check("t6_rst_val", commit_val, 32'd0);
        idle(); cycle();
        check("t6_no_clear", 32'(clear), 32'd0);

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            int r;
            rst_in = ($urandom % 300) != 0;
            rdy_in = ($urandom % 10) != 0;
            issue_valid = $urandom % 2;
            issue_type = 2'($urandom % 3);
            issue_rd = 5'($urandom);
            cdb_valid = 0;
            cdb_val = $urandom; cdb_target = $urandom;
            cdb_mispredict = ($urandom % 6) == 0;
            r = $urandom % 4;
            if (r < 2 && q.size() > 0) begin
                int id;
                id = q[$urandom % q.size()];
                cdb_rob_id = W'(id);
                cdb_valid = !rdy_m[id];
            end else if (r == 2) begin
                cdb_rob_id = W'($urandom);
                cdb_valid = 1;
            end
            search_rob_id_1 = W'($urandom);
            search_rob_id_2 = W'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
